// File: rtl/aes_fifo_pkg.sv
// Shared widths and helpers for the AES256 core's word/block FIFOs.
package aes_fifo_pkg;
    localparam int AES_BLK_W  = 128;
    localparam int AES_KEY_W  = 256;
    localparam int AXI_WORD_W = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction
endpackage

// File: rtl/mod_fifo_blk_to_word_if.sv
// Block-in / word-out bus of the output FIFO, with sticky error reporting.
interface mod_fifo_blk_to_word_if #(
    parameter int BLK_W   = 128,
    parameter int WORD_W  = 32,
    parameter int AVAIL_W = 5
);
    logic [BLK_W-1:0]   inp_blk;
    logic               wr_blk;
    logic               blk_full;
    logic               rd_word;
    logic [WORD_W-1:0]  outp_word;
    logic               word_valid;
    logic [AVAIL_W-1:0] words_avail;
    logic               clr_err;
    logic               overflow;
    logic               underflow;

    modport master (
        output inp_blk, wr_blk, rd_word, clr_err,
        input  blk_full, outp_word, word_valid, words_avail, overflow, underflow
    );

    modport slave (
        input  inp_blk, wr_blk, rd_word, clr_err,
        output blk_full, outp_word, word_valid, words_avail, overflow, underflow
    );
endinterface

// File: rtl/mod_word_sel.sv
// Combinational N:1 word mux; word 0 is the least significant slice of the block.
module mod_word_sel
    import aes_fifo_pkg::*;
#(
    parameter int BLK_W  = AES_BLK_W,
    parameter int WORD_W = AXI_WORD_W,
    parameter int SEL_W  = 2
) (
    input  logic [BLK_W-1:0]  blk,
    input  logic [SEL_W-1:0]  sel,
    output logic [WORD_W-1:0] word
);
    localparam int N = BLK_W / WORD_W;

    logic [WORD_W-1:0] words [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            assign words[gi] = blk[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                word = words[i];
            end
        end
    end
endmodule

// File: rtl/mod_fifo_blk_to_word.sv
// Circular buffer of result blocks, read out as show-ahead words (word 0 = bits [WORD_W-1:0]).
module mod_fifo_blk_to_word
    import aes_fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BLK_W  = AES_BLK_W,
    parameter int WORD_W = AXI_WORD_W
) (
    input  logic            clk,
    input  logic            resetn,
    mod_fifo_blk_to_word_if.slave bus
);
    localparam int N       = BLK_W / WORD_W;
    localparam int PTR_W   = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_W   = clog2(DEPTH + 1);
    localparam int SEL_W   = (N > 1) ? clog2(N) : 1;
    localparam int AVAIL_W = clog2(DEPTH * N + 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);

    logic [BLK_W-1:0]  mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              full;
    logic              valid;
    logic              wr_ok;
    logic              rd_ok;
    logic              pop_blk;
    logic [WORD_W-1:0] head_word;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign valid   = (count_reg != '0);
    assign wr_ok   = bus.wr_blk && !full;
    assign rd_ok   = bus.rd_word && valid;
    assign pop_blk = rd_ok && (sel_reg == LAST_SEL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            sel_reg       <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_reg[wr_ptr_reg] <= bus.inp_blk;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end

            if (rd_ok) begin
                if (sel_reg == LAST_SEL) begin
                    sel_reg    <= '0;
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end else begin
                    sel_reg <= sel_reg + SEL_W'(1);
                end
            end

            case ({wr_ok, pop_blk})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            // A fresh error in the clearing cycle takes priority over the clear.
            if (bus.wr_blk && full) begin
                overflow_reg <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_reg <= 1'b0;
            end

            if (bus.rd_word && !valid) begin
                underflow_reg <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    mod_word_sel #(
        .BLK_W  (BLK_W),
        .WORD_W (WORD_W),
        .SEL_W  (SEL_W)
    ) u_word_sel (
        .blk  (mem_reg[rd_ptr_reg]),
        .sel  (sel_reg),
        .word (head_word)
    );

    assign bus.blk_full    = full;
    assign bus.word_valid  = valid;
    assign bus.outp_word   = valid ? head_word : '0;
    assign bus.words_avail = AVAIL_W'(int'(count_reg) * N - int'(sel_reg));
    assign bus.overflow    = overflow_reg;
    assign bus.underflow   = underflow_reg;
endmodule

// File: tb/tb_mod_fifo_blk_to_word.sv
// Randomized bench for the block-to-word FIFO against a word-queue reference model.
module tb_mod_fifo_blk_to_word;
    import aes_fifo_pkg::*;

    localparam int DEPTH   = 4;
    localparam int BLK_W   = 128;
    localparam int WORD_W  = 32;
    localparam int N       = BLK_W / WORD_W;
    localparam int AVAIL_W = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mod_fifo_blk_to_word_if #(.BLK_W(BLK_W), .WORD_W(WORD_W), .AVAIL_W(AVAIL_W)) bus ();

    mod_fifo_blk_to_word #(.DEPTH(DEPTH), .BLK_W(BLK_W), .WORD_W(WORD_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference: the FIFO seen as a flat queue of words; blocks in use = ceil(words/N).
    logic [WORD_W-1:0] mq[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    function automatic int m_blocks();
        return (mq.size() + N - 1) / N;
    endfunction

    function automatic logic [WORD_W-1:0] m_head();
        return (mq.size() != 0) ? mq[0] : '0;
    endfunction

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic chk(input string name, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h required %0h", name, got, exp);
        else pass_cnt++;
    endtask

    // Apply one clock of stimulus and advance the model with the pre-edge state.
    task automatic cycle(input bit wr, input logic [BLK_W-1:0] blk, input bit rd, input bit clr);
        bit full_pre;
        bit valid_pre;
        full_pre  = (m_blocks() == DEPTH);
        valid_pre = (mq.size() != 0);
        bus.wr_blk  = wr;
        bus.inp_blk = blk;
        bus.rd_word = rd;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (rd) begin
            if (valid_pre) void'(mq.pop_front());
            else m_unf = 1;
        end
        if (wr) begin
            if (!full_pre) for (int i = 0; i < N; i++) mq.push_back(blk[i*WORD_W +: WORD_W]);
            else m_ovf = 1;
        end
        bus.wr_blk  = 1'b0;
        bus.rd_word = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        @(posedge clk);
        #1;
        if (bus.blk_full !== 1'b0 || bus.word_valid !== 1'b0 || bus.words_avail !== '0 ||
            bus.outp_word !== '0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            $display("FAIL reset_outputs: full=%b valid=%b avail=%0d word=%h ovf=%b unf=%b required all 0",
                     bus.blk_full, bus.word_valid, bus.words_avail, bus.outp_word, bus.overflow, bus.underflow);
            total_cnt++;
        end else begin
            total_cnt++;
            pass_cnt++;
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_single_block();
        logic [BLK_W-1:0]  blk;
        logic [WORD_W-1:0] exp_words [4];
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        exp_words[0] = 32'hCCDDEEFF;
        exp_words[1] = 32'h8899AABB;
        exp_words[2] = 32'h44556677;
        exp_words[3] = 32'h00112233;
        cycle(1, blk, 0, 0);
        chk("single_valid", bus.word_valid, 1);
        chk("single_avail", bus.words_avail, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("single_word%0d", i), bus.outp_word, exp_words[i]);
            chk($sformatf("single_avail%0d", i), bus.words_avail, 4 - i);
            $display("single: word %0d = %h", i, bus.outp_word);
            cycle(0, '0, 1, 0);
        end
        chk("single_empty_valid", bus.word_valid, 0);
        chk("single_empty_avail", bus.words_avail, 0);
        chk("single_empty_word", bus.outp_word, 0);
    endtask

    task automatic test_full_overflow();
        logic [WORD_W-1:0] head_before;
        for (int i = 0; i < DEPTH; i++) cycle(1, rand_blk(), 0, 0);
        chk("full_flag", bus.blk_full, 1);
        chk("full_avail", bus.words_avail, 16);
        chk("full_head_model", bus.outp_word, m_head());
        head_before = m_head();
        cycle(1, rand_blk(), 0, 0);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_head_same", bus.outp_word, head_before);
        chk("ovf_avail", bus.words_avail, 16);
        $display("full: 4 blocks stored, 5th dropped, overflow=%b", bus.overflow);
    endtask

    task automatic test_full_write_pop();
        cycle(0, '0, 0, 1);
        chk("clr_ovf", bus.overflow, 0);
        for (int i = 0; i < N - 1; i++) begin
            chk($sformatf("fwp_word%0d", i), bus.outp_word, m_head());
            cycle(0, '0, 1, 0);
        end
        chk("fwp_still_full", bus.blk_full, 1);
        chk("fwp_last_word", bus.outp_word, m_head());
        cycle(1, rand_blk(), 1, 0);
        chk("fwp_avail", bus.words_avail, 12);
        chk("fwp_not_full", bus.blk_full, 0);
        chk("fwp_ovf", bus.overflow, 1);
        chk("fwp_model_avail", bus.words_avail, mq.size());
        $display("full_write_pop: write dropped, avail=%0d", bus.words_avail);
    endtask

    task automatic test_underflow();
        int guard;
        guard = 0;
        while (mq.size() != 0 && guard < 100) begin
            chk("drain_word", bus.outp_word, m_head());
            cycle(0, '0, 1, 0);
            guard++;
        end
        chk("drain_done", bus.word_valid, 0);
        cycle(0, '0, 0, 1);
        chk("unf_clear", bus.underflow, 0);
        cycle(0, '0, 1, 0);
        chk("unf_set", bus.underflow, 1);
        chk("unf_valid", bus.word_valid, 0);
        chk("unf_avail", bus.words_avail, 0);
        cycle(0, '0, 1, 1);
        chk("unf_set_wins", bus.underflow, m_unf);
        chk("unf_still1", bus.underflow, 1);
        $display("underflow: flag=%b after clr+rd on empty", bus.underflow);
    endtask

    task automatic test_stream();
        int sent;
        int recv;
        int cyc;
        bit wr;
        bit rd;
        sent = 0;
        recv = 0;
        cyc  = 0;
        cycle(0, '0, 0, 1);
        while (recv < 10 * N && cyc < 2000) begin
            wr = (sent < 10) && (m_blocks() < DEPTH) && ($urandom_range(0, 3) != 0);
            rd = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
            if (rd) begin
                chk("stream_word", bus.outp_word, m_head());
                $display("stream: cycle %0d pop %h", cyc, bus.outp_word);
                recv++;
            end
            if (wr) sent++;
            cycle(wr, rand_blk(), rd, 0);
            chk("stream_avail", bus.words_avail, mq.size());
            chk("stream_full", bus.blk_full, m_blocks() == DEPTH);
            cyc++;
        end
        chk("stream_count", recv, 10 * N);
        chk("stream_ovf", bus.overflow, 0);
        chk("stream_unf", bus.underflow, 0);
    endtask

    task automatic test_reset_mid();
        logic [BLK_W-1:0] blk;
        cycle(1, rand_blk(), 0, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 1, 0);
        chk("mid_pre_avail", bus.words_avail, 2);
        resetn = 1'b0;
        #2;
        chk("mid_rst_valid", bus.word_valid, 0);
        chk("mid_rst_word", bus.outp_word, 0);
        chk("mid_rst_avail", bus.words_avail, 0);
        chk("mid_rst_full", bus.blk_full, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        cycle(0, '0, 0, 0);
        chk("mid_post_valid", bus.word_valid, 0);
        blk = rand_blk();
        cycle(1, blk, 0, 0);
        chk("mid_new_word0", bus.outp_word, blk[WORD_W-1:0]);
        chk("mid_new_avail", bus.words_avail, N);
        $display("reset_mid: new block head %h", bus.outp_word);
    endtask

    initial begin
        bus.inp_blk = '0;
        bus.wr_blk  = 1'b0;
        bus.rd_word = 1'b0;
        bus.clr_err = 1'b0;
        test_reset();
        test_single_block();
        test_full_overflow();
        test_full_write_pop();
        test_underflow();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
